// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET sequencer: serialises CSR updates, stalls fetch, then redirects once.
// Optional build macro TRAP_VECTORED_MTVEC_EN enables vectored mtvec for interrupts.
module trap_sequencer #(
    parameter int          XLEN          = 64,
    parameter logic [1:0]  RESET_PC_PRIV = 2'b11
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            WB_V,
    input  logic [XLEN-1:0] WB_PC,
    input  logic            EXC_REQ,
    input  logic [XLEN-1:0] EXC_CAUSE,
    input  logic [XLEN-1:0] EXC_TVAL,
    input  logic            EXT_INT,
    input  logic            RET_REQ,
    input  logic [XLEN-1:0] MTVEC_IN,
    input  logic [XLEN-1:0] MEPC_IN,
    input  logic [XLEN-1:0] MSTATUS_IN,
    output logic            CSR_WEN,
    output logic [11:0]     CSR_ADDR,
    output logic [XLEN-1:0] CSR_WDATA,
    output logic            FE_TRAP_STALL,
    output logic            FE_PC_MUX,
    output logic [XLEN-1:0] FE_TARGET,
    output logic [1:0]      PRIV,
    output logic            BUSY,
    output logic [2:0]      DBG_STATE
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        T_MEPC    = 3'd1,
        T_MCAUSE  = 3'd2,
        T_MTVAL   = 3'd3,
        T_MSTATUS = 3'd4,
        R_MSTATUS = 3'd5,
        REDIR     = 3'd6
    } state_t;

    localparam logic [XLEN-1:0] IRQ_CAUSE  = {1'b1, (XLEN-1)'(11)};
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          state_q, state_d;
    logic [1:0]      priv_q;
    logic [XLEN-1:0] cap_pc, cap_cause, cap_tval, cap_mstatus, cap_mtvec, cap_mepc;
    logic            cap_ret;
`ifdef TRAP_VECTORED_MTVEC_EN
    logic            cap_irq;
`endif

    logic            exc_hit, irq_hit, ret_hit, trap_hit;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] trap_mstatus, ret_mstatus;

    // Handshake: an event is accepted on any IDLE edge where it qualifies; there is
    // no backpressure to writeback other than FE_TRAP_STALL, and dropped events are lost.
    always_comb begin
        exc_hit  = WB_V && EXC_REQ;
        irq_hit  = EXT_INT && (MSTATUS_IN[3] || (priv_q != 2'b11));
        ret_hit  = WB_V && RET_REQ;
        trap_hit = exc_hit || irq_hit;
    end

    always_comb begin
        trap_mstatus         = cap_mstatus;
        trap_mstatus[7]      = cap_mstatus[3];
        trap_mstatus[3]      = 1'b0;
        trap_mstatus[12:11]  = priv_q;
        ret_mstatus          = cap_mstatus;
        ret_mstatus[3]       = cap_mstatus[7];
        ret_mstatus[7]       = 1'b1;
        ret_mstatus[12:11]   = 2'b00;
    end

    always_comb begin
`ifdef TRAP_VECTORED_MTVEC_EN
        if (cap_irq && (cap_mtvec[1:0] == 2'b01))
            trap_target = (cap_mtvec & ALIGN_MASK) + {{(XLEN-8){1'b0}}, cap_cause[5:0], 2'b00};
        else
            trap_target = cap_mtvec & ALIGN_MASK;
`else
        trap_target = cap_mtvec & ALIGN_MASK;
`endif
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            priv_q      <= RESET_PC_PRIV;
            cap_pc      <= '0;
            cap_cause   <= '0;
            cap_tval    <= '0;
            cap_mstatus <= '0;
            cap_mtvec   <= '0;
            cap_mepc    <= '0;
            cap_ret     <= 1'b0;
`ifdef TRAP_VECTORED_MTVEC_EN
            cap_irq     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (trap_hit || ret_hit)) begin
                cap_pc      <= WB_PC;
                cap_mstatus <= MSTATUS_IN;
                cap_mtvec   <= MTVEC_IN;
                cap_mepc    <= MEPC_IN;
                cap_ret     <= !trap_hit;
`ifdef TRAP_VECTORED_MTVEC_EN
                cap_irq     <= !exc_hit && irq_hit;
`endif
                if (exc_hit) begin
                    cap_cause <= EXC_CAUSE;
                    cap_tval  <= EXC_TVAL;
                end else if (irq_hit) begin
                    cap_cause <= IRQ_CAUSE;
                    cap_tval  <= '0;
                end else begin
                    cap_cause <= '0;
                    cap_tval  <= '0;
                end
            end
            // Privilege changes only on the redirect edge, so MPP written earlier sees the old level.
            if (state_q == REDIR)
                priv_q <= cap_ret ? cap_mstatus[12:11] : 2'b11;
        end
    end

    always_comb begin
        state_d       = state_q;
        CSR_WEN       = 1'b0;
        CSR_ADDR      = 12'h000;
        CSR_WDATA     = '0;
        FE_TRAP_STALL = 1'b1;
        FE_PC_MUX     = 1'b0;
        FE_TARGET     = '0;
        unique case (state_q)
            IDLE: begin
                FE_TRAP_STALL = trap_hit || ret_hit;
                if (trap_hit)
                    state_d = T_MEPC;
                else if (ret_hit)
                    state_d = R_MSTATUS;
            end
            T_MEPC: begin
                CSR_WEN   = 1'b1;
                CSR_ADDR  = 12'h341;
                CSR_WDATA = cap_pc & ALIGN_MASK;
                state_d   = T_MCAUSE;
            end
            T_MCAUSE: begin
                CSR_WEN   = 1'b1;
                CSR_ADDR  = 12'h342;
                CSR_WDATA = cap_cause;
                state_d   = T_MTVAL;
            end
            T_MTVAL: begin
                CSR_WEN   = 1'b1;
                CSR_ADDR  = 12'h343;
                CSR_WDATA = cap_tval;
                state_d   = T_MSTATUS;
            end
            T_MSTATUS: begin
                CSR_WEN   = 1'b1;
                CSR_ADDR  = 12'h300;
                CSR_WDATA = trap_mstatus;
                state_d   = REDIR;
            end
            R_MSTATUS: begin
                CSR_WEN   = 1'b1;
                CSR_ADDR  = 12'h300;
                CSR_WDATA = ret_mstatus;
                state_d   = REDIR;
            end
            REDIR: begin
                FE_PC_MUX = 1'b1;
                FE_TARGET = cap_ret ? cap_mepc : trap_target;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign PRIV      = priv_q;
    assign BUSY      = (state_q != IDLE);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed + randomized bench for trap_sequencer against a transaction-level reference model.
module tb_trap_sequencer;

    localparam int XLEN = 64;
    localparam int W    = 12 + XLEN;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb_v, exc_req, ext_int, ret_req;
    logic [XLEN-1:0] wb_pc, exc_cause, exc_tval, mtvec_in, mepc_in, mstatus_in;
    logic            csr_wen, fe_trap_stall, fe_pc_mux, busy;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata, fe_target;
    logic [1:0]      priv;
    logic [2:0]      dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] m_priv;
    logic [W-1:0] exp_q[$];

    trap_sequencer #(.XLEN(XLEN), .RESET_PC_PRIV(2'b11)) dut (
        .CLK(clk), .RESET_N(rst_n), .WB_V(wb_v), .WB_PC(wb_pc),
        .EXC_REQ(exc_req), .EXC_CAUSE(exc_cause), .EXC_TVAL(exc_tval),
        .EXT_INT(ext_int), .RET_REQ(ret_req), .MTVEC_IN(mtvec_in),
        .MEPC_IN(mepc_in), .MSTATUS_IN(mstatus_in), .CSR_WEN(csr_wen),
        .CSR_ADDR(csr_addr), .CSR_WDATA(csr_wdata), .FE_TRAP_STALL(fe_trap_stall),
        .FE_PC_MUX(fe_pc_mux), .FE_TARGET(fe_target), .PRIV(priv), .BUSY(busy),
        .DBG_STATE(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive_idle();
        wb_v = 0; exc_req = 0; ext_int = 0; ret_req = 0;
        wb_pc = '0; exc_cause = '0; exc_tval = '0;
        mtvec_in = '0; mepc_in = '0; mstatus_in = '0;
    endtask

    // reference model: mstatus rewrite rules, expressed on the MIE/MPIE/MPP fields
    function automatic logic [XLEN-1:0] model_trap_ms(input logic [XLEN-1:0] ms, input logic [1:0] p);
        logic [XLEN-1:0] r;
        r = ms & ~64'h1888;
        r = r | (64'(ms[3]) << 7) | (64'(p) << 11);
        return r;
    endfunction

    function automatic logic [XLEN-1:0] model_ret_ms(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r = ms & ~64'h1888;
        r = r | (64'(ms[7]) << 3) | 64'h80;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] model_target(input logic [XLEN-1:0] mtvec, input bit is_irq);
        logic [XLEN-1:0] base;
        base = mtvec & ~64'h3;
`ifdef TRAP_VECTORED_MTVEC_EN
        if (is_irq && mtvec[1:0] == 2'b01) return base + 4 * 11;
`endif
        if (is_irq) return base;
        return base;
    endfunction

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        repeat (3) @(negedge clk);
        check("rst_priv", 64'(priv), 64'(2'b11));
        check("rst_busy", 64'(busy), 0);
        check("rst_wen", 64'(csr_wen), 0);
        check("rst_pcmux", 64'(fe_pc_mux), 0);
        check("rst_stall", 64'(fe_trap_stall), 0);
        check("rst_target", fe_target, 0);
        rst_n = 1;
        m_priv = 2'b11;
    endtask

    // One event presented for a single IDLE cycle, then the full sequence is scored.
    task automatic run_event(input bit e_wbv, input bit e_exc, input bit e_irq, input bit e_ret,
                             input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause,
                             input logic [XLEN-1:0] tval, input logic [XLEN-1:0] ms,
                             input logic [XLEN-1:0] mtvec, input logic [XLEN-1:0] mepc);
        bit take_exc, take_irq, take_ret;
        logic [XLEN-1:0] exp_target;
        logic [1:0] exp_priv;
        logic [W-1:0] w;
        @(negedge clk);
        wb_v = e_wbv; exc_req = e_exc; ext_int = e_irq; ret_req = e_ret;
        wb_pc = pc; exc_cause = cause; exc_tval = tval;
        mstatus_in = ms; mtvec_in = mtvec; mepc_in = mepc;
        take_exc = e_wbv && e_exc;
        take_irq = !take_exc && e_irq && (ms[3] || m_priv != 2'b11);
        take_ret = !take_exc && !take_irq && e_wbv && e_ret;
        exp_target = '0;
        exp_priv = m_priv;
        if (take_exc || take_irq) begin
            exp_q.push_back({12'h341, pc & ~64'h3});
            exp_q.push_back({12'h342, take_exc ? cause : 64'h8000_0000_0000_000B});
            exp_q.push_back({12'h343, take_exc ? tval : 64'h0});
            exp_q.push_back({12'h300, model_trap_ms(ms, m_priv)});
            exp_target = model_target(mtvec, take_irq);
            exp_priv = 2'b11;
        end else if (take_ret) begin
            exp_q.push_back({12'h300, model_ret_ms(ms)});
            exp_target = mepc;
            exp_priv = ms[12:11];
        end
        #1;
        check("idle_stall", 64'(fe_trap_stall), 64'(take_exc || take_irq || take_ret));
        check("idle_busy", 64'(busy), 0);
        @(posedge clk);
        #1 drive_idle();
        if (take_exc || take_irq || take_ret) begin
            while (exp_q.size() > 0) begin
                @(negedge clk);
                w = exp_q.pop_front();
                check("seq_wen", 64'(csr_wen), 1);
                check("seq_addr", 64'(csr_addr), 64'(w[W-1:XLEN]));
                check("seq_wdata", csr_wdata, w[XLEN-1:0]);
                check("seq_pcmux", 64'(fe_pc_mux), 0);
                check("seq_stall", 64'(fe_trap_stall), 1);
            end
            @(negedge clk);
            check("redir_pcmux", 64'(fe_pc_mux), 1);
            check("redir_wen", 64'(csr_wen), 0);
            check("redir_target", fe_target, exp_target);
            check("redir_stall", 64'(fe_trap_stall), 1);
            @(negedge clk);
            check("post_busy", 64'(busy), 0);
            check("post_priv", 64'(priv), 64'(exp_priv));
            check("post_pcmux", 64'(fe_pc_mux), 0);
            m_priv = exp_priv;
        end else begin
            @(negedge clk);
            check("drop_busy", 64'(busy), 0);
            check("drop_wen", 64'(csr_wen), 0);
            check("drop_stall", 64'(fe_trap_stall), 0);
        end
    endtask

    initial begin
        do_reset();

        // exception with the canonical values
        run_event(1, 1, 0, 0, 64'h8000_0104, 64'd2, 64'hDEAD_BEEF, 64'h8, 64'h8000_1000, 64'h0);

        // masked interrupt in M-mode: nothing starts
        for (int i = 0; i < 3; i++)
            run_event(0, 0, 1, 0, 64'h8000_0300, 64'h0, 64'h0, 64'h0, 64'h8000_1000, 64'h0);

        // enabled interrupt, vectored mtvec
        run_event(0, 0, 1, 0, 64'h8000_0302, 64'h0, 64'h0, 64'h8, 64'h8000_1001, 64'h0);

        // MRET to U-mode
        run_event(1, 0, 0, 1, 64'h8000_0400, 64'h0, 64'h0, 64'h80, 64'h0, 64'h8000_0200);

        // all three at once, then reset during the mcause write
        @(negedge clk);
        wb_v = 1; exc_req = 1; ext_int = 1; ret_req = 1;
        wb_pc = 64'h8000_0500; exc_cause = 64'd5; exc_tval = 64'h1234;
        mstatus_in = 64'h8; mtvec_in = 64'h8000_1000; mepc_in = 64'h8000_0600;
        #1 check("sim_stall", 64'(fe_trap_stall), 1);
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        check("sim_addr0", 64'(csr_addr), 64'h341);
        @(negedge clk);
        check("sim_addr1", 64'(csr_addr), 64'h342);
        check("sim_cause", csr_wdata, 64'd5);
        rst_n = 0;
        #1;
        check("midrst_busy", 64'(busy), 0);
        check("midrst_wen", 64'(csr_wen), 0);
        check("midrst_priv", 64'(priv), 64'(2'b11));
        @(negedge clk);
        rst_n = 1;
        m_priv = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_wen", 64'(csr_wen), 0);
            check("postrst_pcmux", 64'(fe_pc_mux), 0);
            check("postrst_busy", 64'(busy), 0);
        end

        // randomized events
        for (int i = 0; i < 60; i++) begin
            run_event($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap/return controller between the writeback stage, the CSR file and fetch.
- Accepts one event per handshake from writeback: synchronous exception, external interrupt, or MRET.
- Sequences the required CSR updates through the single CSR write port, one per cycle.
- Holds fetch stalled for the whole sequence, then issues one PC redirect and updates the current privilege level.

Parameters:
- XLEN, 64, datapath width.
- RESET_PC_PRIV, 2'b11, privilege level after reset.

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- WB_V  in  1  writeback instruction valid
- WB_PC  in  XLEN  PC of the writeback instruction
- EXC_REQ  in  1  synchronous exception at writeback
- EXC_CAUSE  in  XLEN  exception code
- EXC_TVAL  in  XLEN  faulting address or instruction
- EXT_INT  in  1  external interrupt level (UART)
- RET_REQ  in  1  MRET at writeback
- MTVEC_IN  in  XLEN  current mtvec
- MEPC_IN  in  XLEN  current mepc
- MSTATUS_IN  in  XLEN  current mstatus
- CSR_WEN  out  1  CSR write strobe
- CSR_ADDR  out  12  CSR address
- CSR_WDATA  out  XLEN  CSR write data
- FE_TRAP_STALL  out  1  stall and flush fetch/decode
- FE_PC_MUX  out  1  one-cycle redirect strobe
- FE_TARGET  out  XLEN  redirect address
- PRIV  out  2  current privilege level
- BUSY  out  1  state is not IDLE

Behaviour:
- Reset values (async, RESET_N=0): state IDLE, PRIV=RESET_PC_PRIV, all other outputs 0, capture registers 0.
- Event qualification in IDLE, fixed priority:
  - Exception: WB_V && EXC_REQ.
  - Interrupt: EXT_INT && (MSTATUS_IN[3] || PRIV!=2'b11).
  - Return: WB_V && RET_REQ.
  - Only the highest-priority event is taken; lower-priority events are dropped, not queued.
- Capture on the qualifying edge: pc, cause, tval, MSTATUS_IN, MTVEC_IN, MEPC_IN.
  - Interrupt cause = {1'b1, 63'd11}.
  - Interrupt tval = 0.
- FE_TRAP_STALL:
  - Combinationally high in IDLE while any qualifying event is present.
  - High in every non-IDLE state.
  - Low in IDLE otherwise.
- Trap path, one CSR write per cycle, CSR_WEN=1 in each write state:
  - T_MEPC: addr 0x341, data = captured pc with bits [1:0] cleared.
  - T_MCAUSE: addr 0x342, data = cause.
  - T_MTVAL: addr 0x343, data = tval.
  - T_MSTATUS: addr 0x300, data = captured mstatus with MPIE[7]=old MIE[3], MIE[3]=0, MPP[12:11]=PRIV; all other bits unchanged.
  - REDIR: FE_PC_MUX=1, FE_TARGET = {mtvec[XLEN-1:2], 2'b00}; PRIV<=2'b11 on this edge; next state IDLE.
- Return path:
  - R_MSTATUS: addr 0x300, data = captured mstatus with MIE=old MPIE, MPIE=1, MPP=2'b00.
  - REDIR: FE_TARGET = captured mepc; PRIV<=old MPP; next state IDLE.
- Latency:
  - Trap: redirect 5 cycles after the capture edge.
  - Return: redirect 2 cycles after the capture edge.
  - IDLE is re-entered the cycle after the redirect; a new event can be accepted in that cycle.
- Inputs other than the captured values are ignored while BUSY=1.
  - EXT_INT rising mid-sequence is re-evaluated only on return to IDLE.
- CSR_WEN and FE_PC_MUX are mutually exclusive and never high in IDLE.
- RESET_N asserted mid-sequence:
  - Immediate return to IDLE with reset values.
  - No partial CSR write is issued after reset deassertion.

Optional Feature:
- Macro: TRAP_VECTORED_MTVEC_EN.
- Defined: when MTVEC_IN[1:0]==2'b01 and the event is an interrupt, trap target = base + 4*cause[5:0], where base = mtvec with [1:0] cleared. Exceptions always use base.
- Not defined: mtvec[1:0] is ignored and the target is always base. Return path is unaffected either way.

Test Plan:
- Reset: hold RESET_N=0 → PRIV=2'b11, all strobes 0, BUSY=0.
- Exception: WB_V=1, EXC_REQ=1, WB_PC=0x80000104, EXC_CAUSE=2, EXC_TVAL=0xDEADBEEF, MSTATUS_IN=0x8, MTVEC_IN=0x80001000 → in order: 0x341←0x80000104, 0x342←2, 0x343←0xDEADBEEF, 0x300←0x1880; then FE_PC_MUX with target 0x80001000 on cycle 5; FE_TRAP_STALL high throughout.
- Masked interrupt: EXT_INT=1, MSTATUS_IN[3]=0, PRIV=M → no sequence starts, BUSY stays 0; setting MIE=1 → cause 0x800000000000000B written, tval 0.
- MRET: RET_REQ=1, WB_V=1, MSTATUS_IN=0x80, MEPC_IN=0x80000200 → 0x300←0x88, redirect to 0x80000200 on cycle 2, PRIV←2'b00.
- Simultaneous EXC_REQ+EXT_INT+RET_REQ → only the exception sequence runs; RESET_N pulsed low during T_MCAUSE → IDLE, no further CSR_WEN.
- With TRAP_VECTORED_MTVEC_EN, MTVEC_IN=0x80001001, interrupt → target 0x8000102C; without the macro → target 0x80001000.
